dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive blocked PEND cycles (legal range 1..15) after which cpu_hold asserts.
REQ-002 SHALL have port clock  input  1  master clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  active-high asynchronous reset.
REQ-004 SHALL have port cpu_addr  input  16  CPU data SRAM address, already registered by the CPU.
REQ-005 SHALL have port cpu_re  input  1  CPU SRAM read enable.
REQ-006 SHALL have port cpu_we  input  1  CPU SRAM write enable.
REQ-007 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-008 SHALL have port cpu_rdata  output  8  CPU read data.
REQ-009 SHALL have port cpu_hold  output  1  stall request to the CPU core.
REQ-010 SHALL have port dma_req  input  1  DMA/debug access request.
REQ-011 SHALL have port dma_we  input  1  DMA direction: 1 is write, 0 is read.
REQ-012 SHALL have port dma_addr  input  16  DMA address.
REQ-013 SHALL have port dma_wdata  input  8  DMA write data.
REQ-014 SHALL have port dma_busy  output  1  DMA request accepted and not yet acknowledged.
REQ-015 SHALL have port dma_ack  output  1  one-cycle completion pulse.
REQ-016 SHALL have port dma_rdata  output  8  DMA read data.
REQ-017 SHALL have port sram_addr  output  16  SRAM address.
REQ-018 SHALL have port sram_re  output  1  SRAM read enable.
REQ-019 SHALL have port sram_we  output  1  SRAM write enable.
REQ-020 SHALL have port sram_wdata  output  8  SRAM write data.
REQ-021 SHALL have port sram_rdata  input  8  SRAM read data, valid in the same cycle that sram_re is high.

Function
REQ-022 SHALL implement the FSM states IDLE, PEND and ACK; there SHALL be no other reachable state.
REQ-023 IDLE: dma_req=1 at a rising edge SHALL capture dma_addr, dma_we and dma_wdata into internal registers and move to PEND; dma_req SHALL be ignored in PEND and ACK.
REQ-024 CPU access is defined as cpu_re|cpu_we; while not holding, the SRAM port SHALL pass it combinationally: sram_addr=cpu_addr, sram_wdata=cpu_wdata, sram_we=cpu_we, sram_re=cpu_re&~cpu_we.
REQ-025 PEND with no CPU access, or with cpu_hold=1, is the DMA issue cycle: the SRAM port SHALL drive the captured request, with sram_re=~we and sram_we=we.
REQ-026 In the DMA issue cycle, CPU re/we SHALL be dropped, and the FSM SHALL move to ACK at the next edge.
REQ-027 PEND with a CPU access and cpu_hold=0 SHALL give the SRAM to the CPU, and the FSM SHALL stay in PEND.
REQ-028 On a DMA read issue cycle, sram_rdata SHALL be registered into dma_rdata; DMA writes SHALL leave dma_rdata unchanged.
REQ-029 ACK SHALL assert dma_ack for exactly one cycle, then return to IDLE; minimum dma_req-sample-to-dma_ack latency is 2 cycles.
REQ-030 dma_busy SHALL be 1 in PEND and ACK, and 0 in IDLE.
REQ-031 A 4-bit wait counter SHALL increment on each blocked PEND cycle, saturate at 15, and clear on any exit from PEND.
REQ-032 cpu_hold SHALL be registered; it SHALL be 1 in PEND once the wait counter equals STARVE_LIMIT, and 0 in every other state.
REQ-033 cpu_hold SHALL deassert on the edge after the DMA issue cycle.
REQ-034 In IDLE and ACK with no CPU access, sram_re and sram_we SHALL be 0, and sram_addr/sram_wdata SHALL hold their last driven values (registered shadow).
REQ-035 cpu_rdata SHALL equal sram_rdata at all times.

Reset
REQ-036 Reset SHALL force state IDLE, wait counter 0, cpu_hold 0, dma_busy 0, dma_ack 0, dma_rdata 8'h00, captured request registers 0 and address/data shadow 0.
REQ-037 Reset asserted in PEND or ACK SHALL abort the transaction with no dma_ack and no SRAM access after reset.

Verification
REQ-038 CPU idle; dma_req read of 16'h0100 holding 8'h5A -> one cycle later sram_re=1 with sram_addr=16'h0100; next cycle dma_ack=1, dma_rdata=8'h5A, dma_busy=0 after.
REQ-039 DMA write 8'hC3 to 16'h0200 while cpu_re active for 3 cycles -> CPU keeps the SRAM those 3 cycles; then sram_we=1 with 16'h0200/8'hC3; then dma_ack.
REQ-040 CPU access every cycle, STARVE_LIMIT=4 -> cpu_hold=1 after 4 blocked cycles; DMA issues that cycle; cpu_hold=0 on the following edge.
REQ-041 dma_req held high through a full transaction -> a second capture occurs only in IDLE after ACK; exactly one dma_ack per transaction.
REQ-042 Reset pulsed while in PEND -> no dma_ack, dma_busy=0, cpu_hold=0, and no DMA access afterward.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data SRAM between the CPU and a
// DMA/debug requester.
//
// The CPU owns the SRAM by default and is passed through combinationally.
// A DMA request is captured in IDLE and waits in PEND for a cycle with no
// CPU access. If the CPU keeps the SRAM busy for STARVE_LIMIT consecutive
// PEND cycles, cpu_hold stalls the core so the DMA can issue. The cycle
// after the DMA issue is ACK, which pulses dma_ack.
//
// Ports
//   clock, reset             master clock, async active-high reset
//   cpu_addr/re/we/wdata     CPU SRAM request (already registered by CPU)
//   cpu_rdata                CPU read data (= sram_rdata)
//   cpu_hold                 registered stall request to the CPU
//   dma_req/we/addr/wdata    DMA request, sampled only in IDLE
//   dma_busy                 request accepted, ack not yet given
//   dma_ack                  one-cycle completion pulse
//   dma_rdata                registered DMA read data
//   sram_addr/re/we/wdata    SRAM port
//   sram_rdata               SRAM read data, same cycle as sram_re
module dm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8  // legal range 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_busy,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] sram_addr,
  output logic        sram_re,
  output logic        sram_we,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } dma_req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  dma_req_t    req_q;
  logic [3:0]  wait_q, wait_nxt;
  logic        hold_nxt;
  logic [15:0] addr_shadow;
  logic [7:0]  wdata_shadow;
  logic        cpu_access;
  logic        dma_issue;
  logic        blocked;

  assign cpu_access = cpu_re | cpu_we;
  // A held CPU may still present re/we; hold forces the DMA through anyway.
  assign dma_issue  = (state == PEND) && (!cpu_access || cpu_hold);
  assign blocked    = (state == PEND) && !dma_issue;

  assign cpu_rdata  = sram_rdata;
  assign dma_busy   = (state != IDLE);
  assign dma_ack    = (state == ACK);

  // Next state, wait counter and hold request.
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      IDLE:    if (dma_req) state_nxt = PEND;
      PEND:    if (dma_issue) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Counter is zero outside PEND, so leaving PEND always clears it.
    if (blocked)
      wait_nxt = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    // Once hold is set the next PEND cycle issues, so the counter never
    // runs past LIMIT while hold is active.
    hold_nxt = (state_nxt == PEND) && (wait_nxt == LIMIT);
  end

  // SRAM port mux: DMA issue, else CPU pass-through, else idle with the
  // last driven address/data held from the shadow registers.
  always_comb begin
    sram_addr  = addr_shadow;
    sram_wdata = wdata_shadow;
    sram_re    = 1'b0;
    sram_we    = 1'b0;
    if (dma_issue) begin
      sram_addr  = req_q.addr;
      sram_wdata = req_q.wdata;
      sram_re    = ~req_q.we;
      sram_we    = req_q.we;
    end else if (cpu_access) begin
      sram_addr  = cpu_addr;
      sram_wdata = cpu_wdata;
      sram_re    = cpu_re & ~cpu_we;
      sram_we    = cpu_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= '0;
      wait_q       <= '0;
      cpu_hold     <= 1'b0;
      dma_rdata    <= 8'h00;
      addr_shadow  <= '0;
      wdata_shadow <= '0;
    end else begin
      state    <= state_nxt;
      wait_q   <= wait_nxt;
      cpu_hold <= hold_nxt;
      if (state == IDLE && dma_req)
        req_q <= '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
      if (dma_issue && !req_q.we)
        dma_rdata <= sram_rdata;
      if (dma_issue || cpu_access) begin
        addr_shadow  <= sram_addr;
        wdata_shadow <= sram_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter with a transaction-level reference model
// and a small behavioural SRAM. Directed sequences cover the basic read,
// CPU-blocked write, starvation hold, held dma_req and reset abort cases.
module tb_dm_arbiter;
  localparam int LIM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_hold;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_busy, dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] sram_addr;
  logic        sram_re, sram_we;
  logic [7:0]  sram_wdata, sram_rdata;

  logic [7:0] mem [0:255];

  always #5 clock = ~clock;

  dm_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_busy(dma_busy), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .sram_addr(sram_addr), .sram_re(sram_re),
    .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: combinational read, write on the clock edge.
  assign sram_rdata = sram_re ? mem[sram_addr[7:0]] : 8'h00;
  always @(posedge clock) if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a request is either absent, waiting, or being acked.
  bit          m_pend, m_ack, m_hold;
  int          m_wait;
  bit          m_rwe;
  logic [15:0] m_raddr, m_sh_addr;
  logic [7:0]  m_rwd, m_rdata, m_sh_wd;
  int          n_capt, n_ack;

  // Observations of the latest cycle, for directed checks.
  logic        o_re, o_we, o_ack, o_busy, o_hold;
  logic [15:0] o_addr;
  logic [7:0]  o_wd, o_rdata;

  task automatic model_reset();
    m_pend = 0; m_ack = 0; m_hold = 0; m_wait = 0;
    m_rwe = 0; m_raddr = '0; m_rwd = '0; m_rdata = '0;
    m_sh_addr = '0; m_sh_wd = '0;
  endtask

  task automatic cyc(input logic r, input logic cre, input logic cwe,
                     input logic [15:0] caddr, input logic [7:0] cwd,
                     input logic dreq, input logic dwe,
                     input logic [15:0] daddr, input logic [7:0] dwd);
    logic acc, turn, ere, ewe;
    logic [15:0] ea;
    logic [7:0]  ew, erd;
    @(negedge clock);
    reset = r; cpu_re = cre; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    #1;
    if (r) model_reset();
    acc  = cre | cwe;
    turn = m_pend && (!acc || m_hold);
    if (turn) begin
      ea = m_raddr; ew = m_rwd; ere = !m_rwe; ewe = m_rwe;
    end else if (acc) begin
      ea = caddr; ew = cwd; ere = cre && !cwe; ewe = cwe;
    end else begin
      ea = m_sh_addr; ew = m_sh_wd; ere = 0; ewe = 0;
    end
    erd = ere ? mem[ea[7:0]] : 8'h00;
    chk("sram_addr", 32'(sram_addr), 32'(ea));
    chk("sram_wdata", 32'(sram_wdata), 32'(ew));
    chk("sram_re", 32'(sram_re), 32'(ere));
    chk("sram_we", 32'(sram_we), 32'(ewe));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(erd));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    chk("dma_busy", 32'(dma_busy), 32'(m_pend | m_ack));
    chk("dma_ack", 32'(dma_ack), 32'(m_ack));
    chk("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
    o_re = sram_re; o_we = sram_we; o_addr = sram_addr; o_wd = sram_wdata;
    o_ack = dma_ack; o_busy = dma_busy; o_hold = cpu_hold; o_rdata = dma_rdata;
    if (dma_ack) n_ack++;
    if (!r) begin
      if (ere || ewe) begin m_sh_addr = ea; m_sh_wd = ew; end
      if (m_ack) m_ack = 0;
      else if (m_pend) begin
        if (turn) begin
          if (!m_rwe) m_rdata = mem[m_raddr[7:0]];
          m_pend = 0; m_ack = 1; m_wait = 0; m_hold = 0;
        end else begin
          m_wait = (m_wait < 15) ? m_wait + 1 : 15;
          m_hold = (m_wait == LIM);
        end
      end else if (dreq) begin
        m_pend = 1; m_rwe = dwe; m_raddr = daddr; m_rwd = dwd; n_capt++;
      end
    end
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
  endtask

  initial begin
    int seen;
    logic [15:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    model_reset();
    n_capt = 0; n_ack = 0;

    // Reset state
    cyc(1, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_rdata", 32'(o_rdata), 0);
    idle(2);

    // Idle CPU, DMA read of 0x0100 holding 0x5A
    mem[8'h00] = 8'h5A;
    cyc(0, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0100, 8'h0);
    cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("rd_issue_re", 32'(o_re), 1);
    chk("rd_issue_addr", 32'(o_addr), 32'h0100);
    cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("rd_ack", 32'(o_ack), 1);
    chk("rd_data", 32'(o_rdata), 32'h5A);
    cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("rd_busy_after", 32'(o_busy), 0);

    // DMA write blocked by 3 CPU reads
    cyc(0, 1, 0, 16'h0010, 8'h0, 1, 1, 16'h0200, 8'hC3);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 16'h0011, 8'h0, 0, 0, 16'h0, 8'h0);
      chk("wr_cpu_owns", 32'(o_addr), 32'h0011);
    end
    cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("wr_issue", {o_we, o_addr, o_wd}, {1'b1, 16'h0200, 8'hC3});
    cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("wr_ack", 32'(o_ack), 1);
    chk("wr_mem", 32'(mem[8'h00]), 32'hC3);

    // Starvation: CPU accesses every cycle
    cyc(0, 1, 0, 16'h0020, 8'h0, 1, 0, 16'h0105, 8'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 1, 0, 16'h0020, 8'h0, 0, 0, 16'h0, 8'h0);
      chk("starve_hold", 32'(o_hold), 32'(k == 5));
      if (k == 5) chk("starve_issue", 32'(o_addr), 32'h0105);
      if (k == 6) chk("starve_ack", 32'(o_ack), 1);
    end
    idle(2);

    // dma_req held high across transactions: one capture and one ack each
    seen = n_ack;
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0107, 8'h0);
    idle(3);
    chk("held_req_acks", 32'(n_ack - seen), 3);

    // Reset while PEND: no ack, no DMA access afterwards
    cyc(0, 1, 1, 16'h0030, 8'h11, 1, 1, 16'h0140, 8'hEE);
    cyc(0, 1, 1, 16'h0031, 8'h22, 0, 0, 16'h0, 8'h0);
    cyc(1, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_hold", 32'(o_hold), 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
      seen += int'(o_ack) + int'(o_re) + int'(o_we);
    end
    chk("abort_quiet", 32'(seen), 0);

    // Randomized traffic with varying CPU load
    for (int i = 0; i < 2500; i++) begin
      int load;
      logic acc, cre, cwe, r;
      case (i / 500)
        0: load = 20; 1: load = 60; 2: load = 95; 3: load = 100; default: load = 50;
      endcase
      acc = ($urandom_range(0, 99) < load);
      cwe = acc && ($urandom_range(0, 2) == 0);
      cre = acc && (!cwe || $urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 199) == 0);
      a   = 16'h0100 + 16'($urandom_range(0, 15));
      cyc(r, cre, cwe, 16'h0100 + 16'($urandom_range(0, 15)), 8'($urandom),
          ($urandom_range(0, 9) < 4), 1'($urandom), a, 8'($urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
